uart_rx: RTL and testbench

//  UART receiver, the counterpart of the team's UART transmitter. Samples the serial line

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte plus done / framing-error pulses.
// The receiver drives the master side; the consumer uses the slave side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_byte;
  logic                 rx_done;
  logic                 frame_error;

  modport master (
    output data_byte,
    output rx_done,
    output frame_error
  );

  modport slave (
    input data_byte,
    input rx_done,
    input frame_error
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start, DATA_BITS data (LSB first), 1 stop.
// Good frames pulse rx_done with the byte; bad stop bits pulse frame_error.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      i_clock,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rx_data,
  uart_rx_if.master rx_bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    START = 7'b0000010,
    DATA  = 7'b0000100,
    STOP  = 7'b0001000,
    DONE  = 7'b0010000,
    ERR   = 7'b0100000,
    BRK   = 7'b1000000
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 err_q;
  logic                 rx_m;
  logic                 rx_s;

  // Line idles high, so the synchronizer resets to 1
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx_data;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (i_tick && !rx_s)
            state <= START;
        end
        START: begin
          if (i_tick) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT)
                state <= STOP;
              else
                bit_cnt <= bit_cnt + BW'(1);
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              state    <= rx_s ? DONE : ERR;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DONE: begin
          data_q <= shreg;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        ERR: begin
          err_q <= 1'b1;
          state <= BRK;
        end
        // A held-low line must be released before a new frame can start
        BRK: begin
          if (i_tick && rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_bus.data_byte   = data_q;
  assign rx_bus.rx_done     = done_q;
  assign rx_bus.frame_error = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with an expectation queue and a pulse monitor.
// Frames are generated by a behavioural transmitter driven off the tick.
module tb_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx = 1'b1;

  int clk_per_tick = 1;
  int div_cnt = 0;
  int tick_count = 0;
  int npass = 0;
  int ntotal = 0;
  logic prev_pulse = 1'b0;

  exp_t sb[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_tick   (tick),
    .i_rx_data(rx),
    .rx_bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick) tick_count <= tick_count + 1;
    if (div_cnt >= clk_per_tick - 1) begin
      div_cnt <= 0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      tick    <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (bus.rx_done || bus.frame_error) begin
        if (sb.size() == 0) begin
          ntotal++;
          $display("FAIL spurious: done=%b err=%b byte=%h with nothing expected",
                   bus.rx_done, bus.frame_error, bus.data_byte);
        end else begin
          e = sb.pop_front();
          check("rx_pulse", {6'd0, bus.rx_done, bus.frame_error, bus.data_byte},
                {6'd0, ~e.err, e.err, e.data});
        end
        if (prev_pulse) begin
          ntotal++;
          $display("FAIL consecutive: pulse on two clocks in a row, got 1 expected 0");
        end
      end
      prev_pulse = bus.rx_done || bus.frame_error;
    end
  end

  task automatic wait_ticks(input int n);
    int tgt;
    tgt = tick_count + n;
    while (tick_count < tgt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int gap);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(16);
    end
    rx = stop_bit;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(gap);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    sb.push_back('{err: 1'b0, data: b});
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check("reset_byte", {8'd0, bus.data_byte}, 16'h0000);
    check("reset_flags", {14'd0, bus.rx_done, bus.frame_error}, 16'h0000);
    rst = 1'b0;
    wait_ticks(10);

    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, 8);

    clk_per_tick = 4;
    wait_ticks(4);
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, 8);
    clk_per_tick = 1;
    wait_ticks(4);

    // Bad stop bit: byte must stay at the last good value
    sb.push_back('{err: 1'b1, data: 8'hA5});
    send_frame(8'h81, 1'b0, 0);
    rx = 1'b0;
    wait_ticks(40);
    rx = 1'b1;
    wait_ticks(20);
    check("err_keeps_byte", {8'd0, bus.data_byte}, 16'h00A5);
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1, 8);

    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(30);
    check("glitch_byte", {8'd0, bus.data_byte}, 16'h0055);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1, 8);

    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h5A);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h5A, 1'b1, 8);
    check("b2b_last", {8'd0, bus.data_byte}, 16'h005A);

    // Abort a frame in the middle of data bit 3
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_byte", {8'd0, bus.data_byte}, 16'h0000);
    check("abort_flags", {14'd0, bus.rx_done, bus.frame_error}, 16'h0000);
    rst = 1'b0;
    rx = 1'b1;
    wait_ticks(40);
    expect_byte(8'hC3);
    send_frame(8'hC3, 1'b1, 8);

    for (int v = 0; v < 256; v++) begin
      expect_byte(v[7:0]);
      send_frame(v[7:0], 1'b1, 1);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 16'(sb.size()), 16'd0);
    check("final_byte", {8'd0, bus.data_byte}, 16'h00FF);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
